// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display path.
//   MAX_DIGITS     : largest digit count the scanner supports
//   SEG_A..SEG_G   : bit positions of each segment in a {g,f,e,d,c,b,a} vector
//   SEG7_LUT       : active-high segment patterns for hex digits 0..F
//   nibble_to_seg7 : table lookup wrapper used by the decoder
package hex_display_pkg;

  localparam int MAX_DIGITS = 16;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] nibble_to_seg7(input logic [3:0] nib);
    return SEG7_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder (active-high output).
//   nibble : hex value 0..F
//   seg    : segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = nibble_to_seg7(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// Multi-digit seven-segment scanner. Snapshots the display word once per
// frame and time-multiplexes the digits with per-digit enable, leading-zero
// blanking, decimal points and an all-dark guard interval at the start of
// each digit slot.
//   clk_i      : system clock
//   reset_i    : synchronous reset, active-high
//   data_i     : hex word, nibble k drives digit k (digit 0 rightmost)
//   digit_en_i : per-digit enable, 0 keeps the digit dark
//   dp_i       : per-digit decimal point request
//   blank_lz_i : enables leading-zero blanking
//   seg_o      : segments {g,f,e,d,c,b,a}
//   dp_o       : decimal point
//   an_o       : digit anodes
//   frame_o    : one-cycle pulse after each snapshot load
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

  // XOR masks that turn active-high values into pin polarity; also the
  // "all off" pin values.
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("hex_display_scanner: NUM_DIGITS must be within 1..16");
    end
    if (REFRESH_DIV <= GUARD_CYCLES) begin : g_bad_refresh
      $error("hex_display_scanner: REFRESH_DIV must exceed GUARD_CYCLES");
    end
  endgenerate

  logic [PW-1:0]         p;
  logic [DW-1:0]         d;
  logic [DATA_W-1:0]     snap_data;
  logic [NUM_DIGITS-1:0] snap_en;
  logic [NUM_DIGITS-1:0] snap_dp;
  logic                  snap_lz;
  logic                  load_pending;

  logic                  p_last;
  logic                  d_last;
  logic                  load;

  assign p_last = (p == P_LAST);
  assign d_last = (d == D_LAST);
  // A fresh snapshot is taken on the last clock of the last digit slot so
  // the new frame starts cleanly at digit 0; load_pending covers the first
  // frame after reset.
  assign load   = load_pending | (p_last & d_last);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p            <= '0;
      d            <= '0;
      snap_data    <= '0;
      snap_en      <= '0;
      snap_dp      <= '0;
      snap_lz      <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      if (p_last) begin
        p <= '0;
        d <= d_last ? '0 : d + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
      if (load) begin
        snap_data    <= data_i;
        snap_en      <= digit_en_i;
        snap_dp      <= dp_i;
        snap_lz      <= blank_lz_i;
        load_pending <= 1'b0;
      end
    end
  end

  // Walk from the most significant digit down, tracking whether every
  // nibble so far is zero. Digit 0 is exempt so zero still shows as "0".
  logic [NUM_DIGITS-1:0] visible;
  logic                  zero_above;

  always_comb begin
    visible    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (snap_data[4*k +: 4] == 4'h0);
      visible[k] = snap_en[k] & ~(snap_lz & zero_above & (k != 0));
    end
  end

  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  show;

  assign cur_nib = 4'(snap_data >> {d, 2'b00});
  assign an_sel  = NUM_DIGITS'(1) << d;
  assign show    = (int'(p) >= GUARD_CYCLES) && visible[d];

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      an_o    <= AN_POL;
      seg_o   <= SEG_POL;
      dp_o    <= SEG_ACTIVE_LOW;
      frame_o <= 1'b0;
    end else begin
      frame_o <= load;
      if (show) begin
        an_o  <= an_sel ^ AN_POL;
        seg_o <= cur_seg ^ SEG_POL;
        dp_o  <= snap_dp[d] ^ SEG_ACTIVE_LOW;
      end else begin
        an_o  <= AN_POL;
        seg_o <= SEG_POL;
        dp_o  <= SEG_ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (8 digits, 4 clocks per slot,
// 1 guard clock, active-low pins) plus a 1-digit instance for frame period.
module tb_hex_display_scanner;

  localparam int ND = 8;
  localparam int RD = 4;
  localparam int GC = 1;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [7:0]  digit_en_i = '1;
  logic [7:0]  dp_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_o;

  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame1;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .digit_en_i(digit_en_i),
    .dp_i(dp_i), .blank_lz_i(blank_lz_i), .seg_o(seg_o), .dp_o(dp_o),
    .an_o(an_o), .frame_o(frame_o)
  );

  hex_display_scanner #(
    .NUM_DIGITS(1), .REFRESH_DIV(RD), .GUARD_CYCLES(GC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i[3:0]),
    .digit_en_i(digit_en_i[0:0]), .dp_i(dp_i[0:0]), .blank_lz_i(blank_lz_i),
    .seg_o(seg1), .dp_o(dp1), .an_o(an1), .frame_o(frame1)
  );

  typedef struct packed {
    logic [7:0]  scen;
    logic [15:0] idx;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: one expected entry per clock, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (an_o !== mon_e.an || seg_o !== mon_e.seg || dp_o !== mon_e.dp ||
          frame_o !== mon_e.frame) begin
        n_fail++;
        $display("FAIL scn%0d_cyc%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b",
                 mon_e.scen, mon_e.idx, an_o, seg_o, dp_o, frame_o,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.frame);
      end
    end
  end

  // 1-digit instance: after the initial load, frames must be 4 clocks apart.
  logic chk1_en = 1'b0;
  int   cnt1 = 0;
  int   pulses1 = 0;

  always @(negedge clk) begin
    if (!chk1_en) begin
      cnt1    = 0;
      pulses1 = 0;
    end else begin
      cnt1++;
      if (frame1 === 1'b1) begin
        pulses1++;
        if (pulses1 >= 3) begin
          n_checks++;
          if (cnt1 != 4) begin
            n_fail++;
            $display("FAIL nd1_frame_period: got %0d cycles, expected 4", cnt1);
          end
        end
        cnt1 = 0;
      end
    end
  end

  task automatic push_reset(input int scen, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.scen = 8'(scen); e.idx = 16'(i);
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Entry i is the output after the i-th edge since release. segs_a holds
  // the hand-decoded first frame, segs_b the second ({d7,...,d0}, active-high).
  task automatic push_run(input int scen, input int count,
                          input logic [55:0] segs_a, input logic [55:0] segs_b,
                          input logic [7:0] vis, input logic [7:0] dpm);
    exp_t e;
    int   slot;
    int   ph;
    logic [6:0] s;
    for (int i = 0; i < count; i++) begin
      slot = (i / RD) % ND;
      ph   = i % RD;
      e.scen  = 8'(scen);
      e.idx   = 16'(i);
      e.frame = (i == 0) || (i % 32 == 31);
      if (ph >= GC && vis[slot]) begin
        s     = (i < 32) ? segs_a[slot*7 +: 7] : segs_b[slot*7 +: 7];
        e.an  = ~(8'(1) << slot);
        e.seg = ~s;
        e.dp  = ~dpm[slot];
      end else begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  // Assert reset for n edges checking the reset state, then release; returns
  // just after the falling edge that precedes the first post-release edge.
  task automatic do_reset(input int scen, input int n);
    @(posedge clk); #1 reset_i = 1'b1;
    @(negedge clk); #1 push_reset(scen, n);
    repeat (n) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_drain(input int scen);
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scn%0d_drain: %0d entries left, expected 0", scen, sb.size());
      sb.delete();
    end
  endtask

  localparam logic [55:0] SEGS_2  = {7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h5B};
  localparam logic [55:0] SEGS_0  = {7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F};
  localparam logic [55:0] SEGS_9  = {7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h6F};
  // 1234_5678
  localparam logic [55:0] SEGS_A3 = {7'h06,7'h5B,7'h4F,7'h66,7'h6D,7'h7D,7'h07,7'h7F};
  // DEAD_BEEF
  localparam logic [55:0] SEGS_B3 = {7'h5E,7'h79,7'h77,7'h5E,7'h7C,7'h79,7'h79,7'h71};
  // 8765_4321
  localparam logic [55:0] SEGS_4  = {7'h7F,7'h07,7'h7D,7'h6D,7'h66,7'h4F,7'h5B,7'h06};

  initial begin
    // 1: data 2, all digits on, no blanking; 1-digit frame period alongside
    data_i = 32'h0000_0002; digit_en_i = 8'hFF; dp_i = 8'h00; blank_lz_i = 1'b0;
    do_reset(1, 3);
    push_run(1, 64, SEGS_2, SEGS_2, 8'hFF, 8'h00);
    chk1_en = 1'b1;
    wait_drain(1);
    chk1_en = 1'b0;

    // 2: leading-zero blanking, data changes to 0 mid-frame
    blank_lz_i = 1'b1;
    do_reset(2, 2);
    push_run(2, 64, SEGS_2, SEGS_0, 8'h01, 8'h00);
    repeat (14) @(posedge clk);
    #1 data_i = 32'h0;
    wait_drain(2);

    // 3: mid-frame data change only appears at the next frame
    blank_lz_i = 1'b0; data_i = 32'h1234_5678;
    do_reset(3, 2);
    push_run(3, 64, SEGS_A3, SEGS_B3, 8'hFF, 8'h00);
    repeat (14) @(posedge clk);
    #1 data_i = 32'hDEAD_BEEF;
    wait_drain(3);

    // 4: sparse enables and a single decimal point
    data_i = 32'h8765_4321; digit_en_i = 8'b1010_1010; dp_i = 8'h02;
    do_reset(4, 2);
    push_run(4, 64, SEGS_4, SEGS_4, 8'hAA, 8'h02);
    wait_drain(4);

    // 5: reset sampled at d=5, p=2, then a fresh frame with new data
    data_i = 32'h0000_0002; digit_en_i = 8'hFF; dp_i = 8'h00;
    do_reset(5, 2);
    push_run(5, 22, SEGS_2, SEGS_2, 8'hFF, 8'h00);
    push_reset(5, 1);
    repeat (22) @(posedge clk);
    #1 reset_i = 1'b1; data_i = 32'h0000_0009;
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk); #1;
    push_run(5, 40, SEGS_9, SEGS_9, 8'hFF, 8'h00);
    wait_drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
